// File: rtl/bmem_line_adapter_pkg.sv
// ============================================================================
//  Module      : bmem_line_adapter_pkg
//  Description : Shared types and constants for the bmem line adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package bmem_line_adapter_pkg;

   localparam int BEAT_W     = 64;
   localparam int BEATS      = 4;
   localparam int LINE_W     = BEAT_W * BEATS;
   localparam int CNT_W      = $clog2(BEATS);
   localparam int LINE_BYTES = LINE_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_REQ   = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_BURST = 3'd3,
      ST_RESP     = 3'd4
   } bmem_state_t;

   typedef enum logic {
      CLIENT_I = 1'b0,
      CLIENT_D = 1'b1
   } client_t;

endpackage

`default_nettype wire

// File: rtl/bmem_line_adapter_if.sv
// ============================================================================
//  Module      : bmem_line_adapter_if
//  Description : bmem pin bundle; master = line adapter, slave = memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bmem_line_adapter_if
   import bmem_line_adapter_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] addr;
   logic              read;
   logic              write;
   logic [BEAT_W-1:0] wdata;
   logic              ready;
   logic [ADDR_W-1:0] raddr;
   logic [BEAT_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output addr, read, write, wdata,
      input  ready, raddr, rdata, rvalid
   );

   modport slave (
      input  addr, read, write, wdata,
      output ready, raddr, rdata, rvalid
   );
endinterface

`default_nettype wire

// File: rtl/bmem_line_adapter_arbiter.sv
// ============================================================================
//  Module      : bmem_rr_arbiter
//  Description : Two-requester round-robin arbiter (I-cache / D-cache).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bmem_rr_arbiter
   import bmem_line_adapter_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_req_i,
   input  logic    d_req_i,
   input  logic    en_i,
   output logic    gnt_vld_o,
   output client_t gnt_o
);

   client_t last_grant_q;
   client_t last_grant_d;

   // On contention favour whichever client was not granted last time
   always_comb begin
      gnt_vld_o    = en_i & (i_req_i | d_req_i);
      gnt_o        = CLIENT_I;
      if (i_req_i && d_req_i) begin
         gnt_o = (last_grant_q == CLIENT_I) ? CLIENT_D : CLIENT_I;
      end else if (d_req_i) begin
         gnt_o = CLIENT_D;
      end
      last_grant_d = gnt_vld_o ? gnt_o : last_grant_q;
   end

   // Remember the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= CLIENT_I;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bmem_line_adapter.sv
// ============================================================================
//  Module      : bmem_line_adapter
//  Description : Arbitrates I/D cache line requests and converts each into a
//                4-beat bmem burst; reassembles read lines and pulses resp.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bmem_line_adapter
   import bmem_line_adapter_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_read,
   output logic [LINE_W-1:0]   i_rdata,
   output logic                i_resp,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [LINE_W-1:0]   d_wdata,
   output logic [LINE_W-1:0]   d_rdata,
   output logic                d_resp,
   bmem_line_adapter_if.master bmem,
   output logic                err
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   bmem_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   client_t           client_q, client_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              err_q, err_d;

   logic              gnt_vld;
   client_t           gnt;
   logic              beat_ok;
   logic              last_beat;

   bmem_rr_arbiter u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req_i   (i_read),
      .d_req_i   (d_read | d_write),
      .en_i      (state_q == ST_IDLE),
      .gnt_vld_o (gnt_vld),
      .gnt_o     (gnt)
   );

   assign beat_ok   = bmem.rvalid && (bmem.raddr == addr_q);
   assign last_beat = (cnt_q == LAST_BEAT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (gnt_vld) state_d = (gnt == CLIENT_D && d_write) ? ST_WR_BURST : ST_RD_REQ;
         ST_RD_REQ:   if (bmem.ready) state_d = ST_RD_WAIT;
         ST_RD_WAIT:  if (beat_ok && last_beat) state_d = ST_RESP;
         ST_WR_BURST: if (bmem.ready && last_beat) state_d = ST_RESP;
         ST_RESP:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output decode: everything is zero unless the state drives it
   always_comb begin
      bmem.addr  = '0;
      bmem.read  = 1'b0;
      bmem.write = 1'b0;
      bmem.wdata = '0;
      i_resp     = 1'b0;
      i_rdata    = '0;
      d_resp     = 1'b0;
      d_rdata    = '0;
      err        = err_q;
      case (state_q)
         ST_RD_REQ: begin
            bmem.read = 1'b1;
            bmem.addr = addr_q;
         end
         ST_WR_BURST: begin
            bmem.write = 1'b1;
            bmem.addr  = addr_q;
            bmem.wdata = wdata_q[int'(cnt_q)*BEAT_W +: BEAT_W];
         end
         ST_RESP: begin
            if (client_q == CLIENT_I) begin
               i_resp  = 1'b1;
               i_rdata = line_q;
            end else begin
               d_resp  = 1'b1;
               d_rdata = wr_q ? '0 : line_q;
            end
         end
         default: ;
      endcase
   end

   // Transaction capture, beat counting, line assembly and error tracking
   always_comb begin
      cnt_d    = cnt_q;
      client_d = client_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      line_d   = line_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               client_d = gnt;
               addr_d   = ((gnt == CLIENT_D) ? d_addr : i_addr) & LINE_MASK;
               wr_d     = (gnt == CLIENT_D) && d_write;
               wdata_d  = d_wdata;
               cnt_d    = '0;
               // Simultaneous read+write is served as a writeback but flagged
               if (gnt == CLIENT_D && d_read && d_write) err_d = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            if (beat_ok) begin
               line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem.rdata;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WR_BURST: begin
            if (bmem.ready) cnt_d = cnt_q + CNT_W'(1);
         end
         ST_RESP: cnt_d = '0;
         default: ;
      endcase
      // Any read beat that is not the expected one is a protocol violation
      if (bmem.rvalid && (state_q != ST_RD_WAIT || !beat_ok)) err_d = 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         client_q <= CLIENT_I;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         line_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         client_q <= client_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         line_q   <= line_d;
         err_q    <= err_d;
      end
   end

endmodule

`default_nettype wire
